// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional HAZARD_STATS_EN adds a saturating count of hazard bubble cycles.
module id_ex_hazard_stage #(
   parameter int unsigned DATA_WIDTH        = 32,
   parameter int unsigned REG_ADDR_WIDTH    = 5,
   parameter int unsigned CTRL_WIDTH        = 8,
   parameter int unsigned LOAD_STALL_CYCLES = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid_in,
   input  logic [DATA_WIDTH-1:0]     id_reg_a_data_in,
   input  logic [DATA_WIDTH-1:0]     id_reg_b_data_in,
   input  logic [REG_ADDR_WIDTH-1:0] id_reg_a_addr_in,
   input  logic [REG_ADDR_WIDTH-1:0] id_reg_b_addr_in,
   input  logic                      id_rs_a_used_in,
   input  logic                      id_rs_b_used_in,
   input  logic [REG_ADDR_WIDTH-1:0] id_wr_addr_in,
   input  logic                      id_wr_ena_in,
   input  logic                      id_mem_rd_in,
   input  logic [CTRL_WIDTH-1:0]     id_ctrl_in,
   input  logic [DATA_WIDTH-1:0]     id_imm_in,
   input  logic                      flush_in,
   input  logic                      ex_stall_in,
   output logic                      ex_valid_out,
   output logic [DATA_WIDTH-1:0]     ex_reg_a_data_out,
   output logic [DATA_WIDTH-1:0]     ex_reg_b_data_out,
   output logic [REG_ADDR_WIDTH-1:0] ex_reg_a_addr_out,
   output logic [REG_ADDR_WIDTH-1:0] ex_reg_b_addr_out,
   output logic [REG_ADDR_WIDTH-1:0] ex_wr_addr_out,
   output logic                      ex_wr_ena_out,
   output logic                      ex_mem_rd_out,
   output logic [CTRL_WIDTH-1:0]     ex_ctrl_out,
   output logic [DATA_WIDTH-1:0]     ex_imm_out,
`ifdef HAZARD_STATS_EN
   output logic [15:0]               stall_cycles_out,
`endif
   output logic                      id_stall_out
);

   localparam int unsigned CNT_W      = 2;
   localparam int unsigned STALL_INIT = (LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0;

   typedef enum logic {RUN, STALL} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hazard;
   logic             load_bubble;
   logic             capture;
   logic             stat_inc;

   // Load in EX whose destination is read by the instruction in ID
   always_comb begin
      hazard = ex_valid_out & ex_mem_rd_out & ex_wr_ena_out &
               (ex_wr_addr_out != '0) & id_valid_in &
               ((id_rs_a_used_in & (id_reg_a_addr_in == ex_wr_addr_out)) |
                (id_rs_b_used_in & (id_reg_b_addr_in == ex_wr_addr_out)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Priority: flush, downstream stall, new hazard, ongoing stall, normal issue
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      load_bubble  = 1'b0;
      capture      = 1'b0;
      stat_inc     = 1'b0;
      id_stall_out = 1'b0;
      if (flush_in) begin
         load_bubble = 1'b1;
         state_d     = RUN;
         cnt_d       = '0;
      end else if (ex_stall_in) begin
         id_stall_out = 1'b1;
      end else if ((state_q == RUN) && hazard) begin
         load_bubble  = 1'b1;
         id_stall_out = 1'b1;
         stat_inc     = 1'b1;
         if (LOAD_STALL_CYCLES > 1) begin
            state_d = STALL;
            cnt_d   = CNT_W'(STALL_INIT);
         end
      end else if (state_q == STALL) begin
         load_bubble  = 1'b1;
         id_stall_out = 1'b1;
         stat_inc     = 1'b1;
         if (cnt_q == '0) state_d = RUN;
         else             cnt_d   = cnt_q - CNT_W'(1);
      end else begin
         capture = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || load_bubble) begin
         ex_valid_out      <= 1'b0;
         ex_reg_a_data_out <= '0;
         ex_reg_b_data_out <= '0;
         ex_reg_a_addr_out <= '0;
         ex_reg_b_addr_out <= '0;
         ex_wr_addr_out    <= '0;
         ex_wr_ena_out     <= 1'b0;
         ex_mem_rd_out     <= 1'b0;
         ex_ctrl_out       <= '0;
         ex_imm_out        <= '0;
      end else if (capture) begin
         ex_valid_out      <= id_valid_in;
         ex_reg_a_data_out <= id_reg_a_data_in;
         ex_reg_b_data_out <= id_reg_b_data_in;
         ex_reg_a_addr_out <= id_reg_a_addr_in;
         ex_reg_b_addr_out <= id_reg_b_addr_in;
         ex_wr_addr_out    <= id_wr_addr_in;
         ex_wr_ena_out     <= id_wr_ena_in & id_valid_in;
         ex_mem_rd_out     <= id_mem_rd_in & id_valid_in;
         ex_ctrl_out       <= id_ctrl_in;
         ex_imm_out        <= id_imm_in;
      end
   end

`ifdef HAZARD_STATS_EN
   // Saturating count of hazard-induced bubble cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        stall_cycles_out <= '0;
      else if (stat_inc && (stall_cycles_out != '1))  stall_cycles_out <= stall_cycles_out + 16'd1;
   end
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage; u1 uses one bubble per hazard, u3 uses three.
`timescale 1ns/1ps
module tb_id_ex_hazard_stage;

   logic        clk, rst;
   logic        id_valid, a_used, b_used, wr_ena, mem_rd, flush, ex_stall;
   logic [31:0] a_data, b_data, imm;
   logic [4:0]  a_addr, b_addr, wr_addr;
   logic [7:0]  ctrl;

   logic        v1, we1, mr1, st1, v3, we3, mr3, st3;
   logic [31:0] ad1, bd1, im1, ad3, bd3, im3;
   logic [4:0]  aa1, ba1, wa1, aa3, ba3, wa3;
   logic [7:0]  c1, c3;
`ifdef HAZARD_STATS_EN
   logic [15:0] sc1, sc3;
`endif

   int checks = 0;
   int failures = 0;

   id_ex_hazard_stage #(.LOAD_STALL_CYCLES(1)) u1 (
      .clk(clk), .rst(rst), .id_valid_in(id_valid),
      .id_reg_a_data_in(a_data), .id_reg_b_data_in(b_data),
      .id_reg_a_addr_in(a_addr), .id_reg_b_addr_in(b_addr),
      .id_rs_a_used_in(a_used), .id_rs_b_used_in(b_used),
      .id_wr_addr_in(wr_addr), .id_wr_ena_in(wr_ena), .id_mem_rd_in(mem_rd),
      .id_ctrl_in(ctrl), .id_imm_in(imm), .flush_in(flush), .ex_stall_in(ex_stall),
      .ex_valid_out(v1), .ex_reg_a_data_out(ad1), .ex_reg_b_data_out(bd1),
      .ex_reg_a_addr_out(aa1), .ex_reg_b_addr_out(ba1), .ex_wr_addr_out(wa1),
      .ex_wr_ena_out(we1), .ex_mem_rd_out(mr1), .ex_ctrl_out(c1), .ex_imm_out(im1),
`ifdef HAZARD_STATS_EN
      .stall_cycles_out(sc1),
`endif
      .id_stall_out(st1));

   id_ex_hazard_stage #(.LOAD_STALL_CYCLES(3)) u3 (
      .clk(clk), .rst(rst), .id_valid_in(id_valid),
      .id_reg_a_data_in(a_data), .id_reg_b_data_in(b_data),
      .id_reg_a_addr_in(a_addr), .id_reg_b_addr_in(b_addr),
      .id_rs_a_used_in(a_used), .id_rs_b_used_in(b_used),
      .id_wr_addr_in(wr_addr), .id_wr_ena_in(wr_ena), .id_mem_rd_in(mem_rd),
      .id_ctrl_in(ctrl), .id_imm_in(imm), .flush_in(flush), .ex_stall_in(ex_stall),
      .ex_valid_out(v3), .ex_reg_a_data_out(ad3), .ex_reg_b_data_out(bd3),
      .ex_reg_a_addr_out(aa3), .ex_reg_b_addr_out(ba3), .ex_wr_addr_out(wa3),
      .ex_wr_ena_out(we3), .ex_mem_rd_out(mr3), .ex_ctrl_out(c3), .ex_imm_out(im3),
`ifdef HAZARD_STATS_EN
      .stall_cycles_out(sc3),
`endif
      .id_stall_out(st3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one ID instruction; comb outputs settle after a short delay
   task automatic instr(input logic v, input logic [4:0] aa, input logic au,
                        input logic [4:0] ba, input logic bu, input logic [4:0] wa,
                        input logic we, input logic mr, input logic [31:0] ad);
      id_valid = v; a_addr = aa; a_used = au; b_addr = ba; b_used = bu;
      wr_addr = wa; wr_ena = we; mem_rd = mr; a_data = ad;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
      b_data = 32'h0; imm = 32'h0; ctrl = 8'h0;
      instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
      tick();
      chk("rst_valid", 32'(v1), 32'd0);
      chk("rst_wr_addr", 32'(wa1), 32'd0);
      chk("rst_stall", 32'(st3), 32'd0);
      rst = 1'b0;

      // One-bubble load-use: lw r3 ; add r4,r3,r1
      instr(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b1, 1'b1, 32'h100);
      tick();
      chk("lw_in_ex_valid", 32'(v1), 32'd1);
      chk("lw_in_ex_mem_rd", 32'(mr1), 32'd1);
      instr(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 32'h200);
      chk("lu1_stall", 32'(st1), 32'd1);
      tick();
      chk("lu1_bubble", 32'(v1), 32'd0);
      chk("lu1_stall_drop", 32'(st1), 32'd0);
      tick();
      chk("lu1_add_valid", 32'(v1), 32'd1);
      chk("lu1_add_a_addr", 32'(aa1), 32'd3);
      chk("lu1_add_a_data", ad1, 32'h200);

      // r0 destination never hazards; unused rs_b never hazards
      do_reset();
      instr(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 32'h0);
      tick();
      instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 32'h55);
      chk("r0_no_stall", 32'(st1), 32'd0);
      tick();
      chk("r0_issue_wr", 32'(wa1), 32'd5);
      instr(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b1, 1'b1, 32'h0);
      tick();
      instr(1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 5'd6, 1'b1, 1'b0, 32'h66);
      chk("rsb_unused_no_stall", 32'(st1), 32'd0);
      tick();
      chk("rsb_issue_valid", 32'(v1), 32'd1);
      chk("rsb_issue_wr", 32'(wa1), 32'd6);
      instr(1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 32'h0);
      tick();
      chk("inv_valid", 32'(v1), 32'd0);
      chk("inv_wr_ena", 32'(we1), 32'd0);
      chk("inv_mem_rd", 32'(mr1), 32'd0);

      // Three-bubble load-use on r7 via rs_b
      do_reset();
      instr(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 1'b1, 1'b1, 32'h0);
      tick();
      instr(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 32'h77);
      chk("lu3_stall_c1", 32'(st3), 32'd1);
      tick();
      chk("lu3_bubble_1", 32'(v3), 32'd0);
      chk("lu3_stall_c2", 32'(st3), 32'd1);
      tick();
      chk("lu3_bubble_2", 32'(v3), 32'd0);
      chk("lu3_stall_c3", 32'(st3), 32'd1);
      tick();
      chk("lu3_bubble_3", 32'(v3), 32'd0);
      chk("lu3_stall_end", 32'(st3), 32'd0);
`ifdef HAZARD_STATS_EN
      chk("lu3_stats", 32'(sc3), 32'd3);
`endif
      tick();
      chk("lu3_issue_valid", 32'(v3), 32'd1);
      chk("lu3_issue_wr", 32'(wa3), 32'd8);

      // Flush while in STALL aborts remaining bubbles
      do_reset();
      instr(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 1'b1, 1'b1, 32'h0);
      tick();
      instr(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 32'h77);
      tick();
      chk("fl_in_stall", 32'(st3), 32'd1);
      flush = 1'b1;
      #1;
      chk("fl_stall_low", 32'(st3), 32'd0);
      tick();
      flush = 1'b0;
      instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 32'h99);
      chk("fl_bubble", 32'(v3), 32'd0);
      chk("fl_run_no_stall", 32'(st3), 32'd0);
      tick();
      chk("fl_issue_valid", 32'(v3), 32'd1);
      chk("fl_issue_wr", 32'(wa3), 32'd9);

      // Downstream stall freezes EX with the load in it
      do_reset();
      instr(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b1, 1'b1, 32'h0);
      tick();
      instr(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 32'h44);
      ex_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("xs_stall", 32'(st1), 32'd1);
         tick();
         chk("xs_hold_valid", 32'(v1), 32'd1);
         chk("xs_hold_wr", 32'(wa1), 32'd3);
         chk("xs_hold_mem_rd", 32'(mr1), 32'd1);
      end
      ex_stall = 1'b0;
      #1;
      chk("xs_hazard_fires", 32'(st1), 32'd1);
      tick();
      chk("xs_bubble", 32'(v1), 32'd0);
      tick();
      chk("xs_issue_a_addr", 32'(aa1), 32'd3);
      chk("xs_issue_valid", 32'(v1), 32'd1);

      // Asynchronous reset mid-stream: u1 holds a valid instr, u3 is in STALL
      do_reset();
      instr(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 1'b1, 1'b1, 32'h0);
      tick();
      instr(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 32'h88);
      tick();
      tick();
      chk("ar_pre_u1_valid", 32'(v1), 32'd1);
      chk("ar_pre_u3_stall", 32'(st3), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_u1_valid", 32'(v1), 32'd0);
      chk("ar_u1_wr", 32'(wa1), 32'd0);
      chk("ar_u1_a_data", ad1, 32'd0);
      chk("ar_u3_stall", 32'(st3), 32'd0);
      rst = 1'b0;
      instr(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0, 32'hA0);
      tick();
      chk("ar_u1_first", 32'(wa1), 32'd10);
      chk("ar_u3_first", 32'(wa3), 32'd10);
      chk("ar_u3_valid", 32'(v3), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
